// File: rtl/dmem_bus_ctrl.sv
// Memory-stage data bus controller: one req/ack bus transaction per LSU access, with pipeline stall and load extension.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        rd,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic        misalign
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_rd;
    logic [3:0]      r_code;
    logic [1:0]      r_off;
    logic            r_bus_req;
    logic            r_bus_we;
    logic [31:0]     r_bus_addr;
    logic [3:0]      r_bus_be;
    logic [31:0]     r_bus_wdata;
    logic [31:0]     r_load_data;
    logic            r_bus_err;
    logic            r_misalign;

    logic [31:0]     w_wdata;
    logic [31:0]     w_load;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic            w_misalign;

    always_comb begin
        w_wdata = wdata;
        case (mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_wdata = {4{wdata[7:0]}};
            4'b0011, 4'b1100:                   w_wdata = {2{wdata[15:0]}};
            default:                            w_wdata = wdata;
        endcase
    end

    always_comb begin
        w_byte = bus_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_code)
            4'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            4'd1:    w_load = {{16{w_half[15]}}, w_half};
            4'd3:    w_load = {24'd0, w_byte};
            4'd4:    w_load = {16'd0, w_half};
            default: w_load = bus_rdata;
        endcase
    end

`ifdef DMEM_MISALIGN_CHK_EN
    always_comb begin
        w_misalign = 1'b0;
        if (rd) begin
            case (mask)
                4'd0, 4'd3: w_misalign = 1'b0;
                4'd1, 4'd4: w_misalign = addr[0];
                default:    w_misalign = |addr[1:0];
            endcase
        end else begin
            case (mask)
                4'b0011, 4'b1100: w_misalign = addr[0];
                4'b1111:          w_misalign = |addr[1:0];
                default:          w_misalign = 1'b0;
            endcase
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rd        <= 1'b0;
            r_code      <= '0;
            r_off       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_load_data <= '0;
            r_bus_err   <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!cs) begin
                        r_rd   <= rd;
                        r_code <= mask;
                        r_off  <= addr[1:0];
                        r_cnt  <= '0;
                        if (w_misalign) begin
                            r_state    <= S_DONE;
                            r_misalign <= 1'b1;
                            if (rd)
                                r_load_data <= '0;
                        end else begin
                            r_state     <= S_BUSY;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= ~rd;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_be    <= rd ? 4'b1111 : mask;
                            r_bus_wdata <= w_wdata;
                        end
                    end
                end
                S_BUSY: begin
                    // Ack is tested first so an ack in the final allowed cycle beats the timeout.
                    if (bus_ack) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        if (r_rd)
                            r_load_data <= w_load;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (r_rd)
                            r_load_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_bus_err  <= 1'b0;
                    r_misalign <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall     = ((r_state == S_IDLE) & ~cs) | (r_state == S_BUSY);
    assign load_data = r_load_data;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;
    assign bus_err   = r_bus_err;
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed plan cases plus randomized accesses against a behavioural model.
module tb_dmem_bus_ctrl;

    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs;
    logic        rd;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    int req_bursts = 0;
    int exp_bursts = 0;
    logic [31:0] exp_ld = '0;

    always #5 clk = ~clk;

    always @(posedge bus_req) req_bursts++;

    dmem_bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .mask(mask), .addr(addr),
        .wdata(wdata), .stall(stall), .load_data(load_data), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err), .misalign(misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [3:0] code, input logic [1:0] off, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (code)
            4'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            4'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            4'd3:    return b;
            4'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] m, input logic [31:0] w);
        case ($countones(m))
            1:       return (w & 32'hFF) * 32'h01010101;
            2:       return (w & 32'hFFFF) * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic bit m_mis(input bit r, input logic [3:0] m, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHK_EN
        if (r) begin
            if (m == 4'd0 || m == 4'd3) return 1'b0;
            if (m == 4'd1 || m == 4'd4) return (a % 2) != 0;
            return (a % 4) != 0;
        end
        if ($countones(m) == 2) return (a % 2) != 0;
        if (m == 4'hF) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Called just after a rising edge; returns just after the edge that ends the DONE cycle.
    // k = ack cycle (1..TO), 0 = never ack.
    task automatic access(input bit r, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdt, input int unsigned k);
        bit mis;
        bit exp_err;
        int unsigned last;
        mis = m_mis(r, m, a);
        exp_err = 1'b0;
        cs = 1'b0; rd = r; mask = m; addr = a; wdata = wd; bus_rdata = rdt; bus_ack = 1'b0;
        @(negedge clk);
        chk("c0_stall", 32'(stall), 1);
        chk("c0_req", 32'(bus_req), 0);
        chk("c0_err", 32'(bus_err), 0);
        chk("c0_mis", 32'(misalign), 0);
        @(posedge clk); #1;
        if (!mis) begin
            exp_bursts++;
            last = (k == 0) ? TO : k;
            for (int unsigned i = 1; i <= last; i++) begin
                bus_ack = (i == k);
                @(negedge clk);
                if (i == 1 || i == last) begin
                    chk("busy_stall", 32'(stall), 1);
                    chk("busy_req", 32'(bus_req), 1);
                    chk("busy_we", 32'(bus_we), 32'(!r));
                    chk("busy_addr", bus_addr, a - (a % 4));
                    chk("busy_be", 32'(bus_be), r ? 32'hF : 32'(m));
                    if (!r) chk("busy_wdata", bus_wdata, m_wdata(m, wd));
                end
                @(posedge clk); #1;
            end
            bus_ack = 1'b0;
            exp_err = (k == 0);
            if (r) exp_ld = exp_err ? 32'h0 : m_load(m, a[1:0], rdt);
        end else if (r) begin
            exp_ld = 32'h0;
        end
        @(negedge clk);
        chk("done_stall", 32'(stall), 0);
        chk("done_req", 32'(bus_req), 0);
        chk("done_err", 32'(bus_err), 32'(exp_err));
        chk("done_mis", 32'(misalign), 32'(mis));
        chk("done_ld", load_data, exp_ld);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int unsigned n, input logic ack);
        cs = 1'b1; bus_ack = ack;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_stall", 32'(stall), 0);
            chk("idle_req", 32'(bus_req), 0);
            chk("idle_ld", load_data, exp_ld);
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
    endtask

    initial begin
        logic [3:0] smask [7];
        bit r;
        logic [3:0] m;
        smask = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

        rst_n = 1'b0; cs = 1'b0; rd = 1'b1; mask = '0; addr = '0; wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #3;
        chk("rst_stall_cs0", 32'(stall), 1);
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", 32'(bus_be), 0);
        chk("rst_ld", load_data, 0);
        chk("rst_err", 32'(bus_err), 0);
        chk("rst_mis", 32'(misalign), 0);
        cs = 1'b1; #1;
        chk("rst_stall_cs1", 32'(stall), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 4'd0, 32'h103, 32'h0, 32'h80112233, 1);
        chk("plan_lb", load_data, 32'hFFFFFF80);
        idle(2, 1'b1);
        access(1'b0, 4'b1100, 32'h202, 32'h0000ABCD, 32'h0, 3);
        chk("plan_sh_ld_held", load_data, 32'hFFFFFF80);
        access(1'b1, 4'd4, 32'h2, 32'h0, 32'hF00D1234, 2);
        chk("plan_lhu", load_data, 32'h0000F00D);
        access(1'b1, 4'd2, 32'h0, 32'h0, 32'hF00D1234, 1);
        chk("plan_lw", load_data, 32'hF00D1234);

        access(1'b1, 4'd2, 32'h40, 32'h0, 32'h12345678, 0);
        chk("plan_timeout_ld", load_data, 32'h0);
        idle(1, 1'b0);
        chk("plan_err_once", 32'(bus_err), 0);
        access(1'b1, 4'd2, 32'h44, 32'h0, 32'hCAFEF00D, TO);
        chk("plan_ack_last", load_data, 32'hCAFEF00D);

        access(1'b1, 4'd0, 32'h10, 32'h0, 32'h000000AA, 1);
        access(1'b1, 4'd3, 32'h11, 32'h0, 32'h0000BB00, 2);
        chk("b2b_lbu", load_data, 32'h000000BB);
        idle(1, 1'b0);

        access(1'b1, 4'd2, 32'h6, 32'h0, 32'h55667788, 1);
        idle(1, 1'b0);

        cs = 1'b0; rd = 1'b1; mask = 4'd2; addr = 32'h80; bus_ack = 1'b0;
        exp_bursts++;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        chk("midrst_req", 32'(bus_req), 0);
        chk("midrst_stall", 32'(stall), 1);
        exp_ld = 32'h0;
        cs = 1'b1; bus_ack = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1; bus_ack = 1'b0;
        @(negedge clk);
        chk("midrst_ld", load_data, 32'h0);
        chk("midrst_err", 32'(bus_err), 0);
        @(posedge clk); #1;

        for (int n = 0; n < 60; n++) begin
            r = 1'($urandom_range(0, 1));
            m = r ? 4'($urandom_range(0, 7)) : smask[$urandom_range(0, 6)];
            access(r, m, $urandom, $urandom, $urandom, $urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) idle(1, 1'($urandom_range(0, 1)));
        end
        idle(1, 1'b0);

        chk("req_bursts", 32'(req_bursts), 32'(exp_bursts));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
